spi_master_mw: RTL and testbench
================================

// Module: spi_master_mw
// PURPOSE
//  Parametrised multi-word SPI master; next generation of the fixed 16+16-bit master. Streams any number of
//  words per SS-low transaction via valid/ready; runtime word length, bit order, all 4 modes, NUM_SS selects.
//  Sits between a register/DMA front end and off-chip SPI slaves.
// PARAMETERS
//  DATA_W   32  max bits per word (2..64)
//  NUM_SS    4  slave-select lines (1..16)
//  DIV_W    16  width of i_divider
// PORTS
//  i_clk          in   1          system clock; the only clock
//  i_rst_n        in   1          asynchronous reset, active low
//  i_divider      in   DIV_W      half-SCLK period = i_divider+1 i_clk cycles
//  i_cpol         in   1          SCLK idle level
//  i_cpha         in   1          0: sample leading edge; 1: sample trailing edge
//  i_lsb_first    in   1          1: shift LSB first
//  i_word_len     in   clog2(DATA_W+1)  bits per word; 0 or >DATA_W means DATA_W
//  i_ss_sel       in   clog2(NUM_SS)    slave to assert (max(1,..) wide)
//  i_tx_data      in   DATA_W     word to send, right-justified
//  i_tx_last      in   1          word is last of transaction
//  i_tx_valid     in   1          tx word offered
//  o_tx_ready     out  1          tx word accepted when valid&ready
//  o_rx_data      out  DATA_W     received word, right-justified, upper bits 0
//  o_rx_valid     out  1          one-cycle pulse, o_rx_data valid
//  o_busy         out  1          transaction in progress
//  o_sclk         out  1          SPI clock
//  o_ss_n         out  NUM_SS     active-low slave selects, one-hot-low when active
//  o_mosi         out  1          serial out
//  i_miso         in   1          serial in
// BEHAVIOUR
//  Reset (async, immediate): o_ss_n all 1, o_sclk=0, o_mosi=0, o_busy=0, o_tx_ready=0, o_rx_valid=0,
//   o_rx_data=0, FSM IDLE, divider counter 0. Reset mid-transfer aborts with no further SCLK edge.
//  Tick: counter 0..i_divider, wraps; FSM advances only on tick except handshake/rx_valid (every i_clk).
//  Config (cpol,cpha,lsb_first,word_len,ss_sel) latched at transaction start; in IDLE o_sclk tracks i_cpol.
//  o_tx_ready=1 only in IDLE and in WAIT; word accepted on same i_clk edge; ready drops next cycle.
//  FSM: IDLE -accept-> SETUP: assert o_ss_n[sel], load shifter, CPHA0 drives first bit; 1 tick.
//   SHIFT: 2 ticks/bit: leading edge (SCLK toggles from idle), trailing edge (back to idle).
//    CPHA0: sample on leading, drive next bit on trailing. CPHA1: drive on leading, sample on trailing.
//    After word_len bits: o_rx_valid pulse 1 cycle, to WAIT (last=0) or STOP (last=1).
//   WAIT: SS held low, SCLK idle, tx_ready=1; stall indefinitely until valid (no underflow error);
//    accept -> SETUP-less reload, SHIFT next tick.
//   STOP: 1 tick SS-to-end hold, then deassert o_ss_n, o_mosi=0; GAP: 1 tick SS high; -> IDLE, o_busy=0.
//  o_busy=1 from accept cycle until GAP exit. Min transaction = word_len*2+3 ticks.
//  i_divider=0: tick every cycle, SCLK = i_clk/2. Changing i_divider mid-transfer: takes effect at wrap.
//  word_len=1 legal. MSB-first sends bit word_len-1 first; LSB-first sends bit 0 first.
//  Rx assembled with same bit order as tx; unused upper bits of o_rx_data forced 0.
//  i_ss_sel >= NUM_SS: selects nothing (all o_ss_n=1), transfer still clocks.
// CONFIGURATION
//  SPI_MASTER_MW_LOOPBACK_EN defined: adds port i_loopback (in,1); when 1, received bit = o_mosi
//   (internal), i_miso ignored, pins unchanged. Undefined: port absent, rx always from i_miso.
// TESTING
//  1 Mode0, len 8, MSB, div 1, tx 0xA5 last=1, miso echoes mosi -> 8 SCLK rising edges, MOSI 10100101,
//    rx 0xA5 pulse once, o_ss_n[sel] low through transfer, busy drops after GAP.
//  2 All 4 modes, len 16, tx 0x1234, slave model sends 0xBEEF -> rx 0xBEEF each mode; idle SCLK = cpol.
//  3 Burst 3 words 0x11,0x22,0x33 (last on 3rd), stall 50 cycles before word 2 -> SS stays low, SCLK
//    idle during stall, 3 rx pulses, exactly 24 SCLK periods.
//  4 LSB-first len 5 tx 0x13 -> MOSI 1,1,0,0,1; rx upper DATA_W-5 bits 0.
//  5 Assert i_rst_n low mid bit 3 -> o_ss_n all 1, o_sclk 0, busy 0 immediately; next transfer clean.
//  6 LOOPBACK_EN built, i_loopback=1, miso tied 0, tx 0xDEADBEEF len 32 -> rx 0xDEADBEEF.

Source files
------------

// File: rtl/spi_master_mw.sv
// Multi-word SPI master: valid/ready word stream, runtime word length, bit order, SPI mode and slave select.
// Optional build macro SPI_MASTER_MW_LOOPBACK_EN adds i_loopback (received bit taken from o_mosi).
module spi_master_mw #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned DIV_W  = 16,
   localparam int unsigned LW    = $clog2(DATA_W + 1),
   localparam int unsigned SW    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DIV_W-1:0]  i_divider,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic              i_lsb_first,
   input  logic [LW-1:0]     i_word_len,
   input  logic [SW-1:0]     i_ss_sel,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_last,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   output logic              o_busy,
   output logic              o_sclk,
   output logic [NUM_SS-1:0] o_ss_n,
   output logic              o_mosi,
   input  logic              i_miso
`ifdef SPI_MASTER_MW_LOOPBACK_EN
   ,
   input  logic              i_loopback
`endif
);

   localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_WAIT, ST_STOP, ST_GAP} state_t;

   state_t              state_q;
   logic [DIV_W-1:0]    cnt_q, div_q;
   logic                cpol_q, cpha_q, lsb_q, last_q, lead_q;
   logic [LW-1:0]       len_q, bit_q;
   logic [DATA_W-1:0]   tx_q, rx_sh_q, rx_sh_d, rx_data_q;
   logic                rx_valid_q, busy_q, sclk_q, mosi_q, tx_ready_q;
   logic [NUM_SS-1:0]   ss_n_q;

   logic                tick, accept, rx_bit;
   logic [LW-1:0]       len_in;
   logic [IW-1:0]       pos_cur, pos_nxt;

   // Bit position within the word for the idx-th bit on the wire.
   function automatic logic [IW-1:0] bit_pos(input logic lsb, input logic [LW-1:0] len,
                                             input logic [LW-1:0] idx);
      logic [LW-1:0] p;
      p = lsb ? idx : (len - LW'(1) - idx);
      return p[IW-1:0];
   endfunction

   function automatic logic [NUM_SS-1:0] ss_decode(input logic [SW-1:0] sel);
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
         if (sel == SW'(i)) v[i] = 1'b0;
      end
      return v;
   endfunction

   always_comb begin
      tick    = (cnt_q == div_q);
      accept  = i_tx_valid & tx_ready_q;
      len_in  = (i_word_len == '0 || i_word_len > LW'(DATA_W)) ? LW'(DATA_W) : i_word_len;
      pos_cur = bit_pos(lsb_q, len_q, bit_q);
      pos_nxt = bit_pos(lsb_q, len_q, bit_q + LW'(1));
`ifdef SPI_MASTER_MW_LOOPBACK_EN
      rx_bit  = i_loopback ? mosi_q : i_miso;
`else
      rx_bit  = i_miso;
`endif
      rx_sh_d = rx_sh_q;
      rx_sh_d[pos_cur] = rx_bit;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         last_q     <= 1'b0;
         lead_q     <= 1'b1;
         len_q      <= '0;
         bit_q      <= '0;
         tx_q       <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         ss_n_q     <= '1;
      end else begin
         rx_valid_q <= 1'b0;
         // Divider is re-read only at wrap so a mid-transfer change never shortens the current half period.
         cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
         if (tick) div_q <= i_divider;
         case (state_q)
            ST_IDLE: begin
               sclk_q     <= i_cpol;
               tx_ready_q <= 1'b1;
               if (accept) begin
                  tx_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  cnt_q      <= '0;
                  div_q      <= i_divider;
                  cpol_q     <= i_cpol;
                  cpha_q     <= i_cpha;
                  lsb_q      <= i_lsb_first;
                  len_q      <= len_in;
                  ss_n_q     <= ss_decode(i_ss_sel);
                  tx_q       <= i_tx_data;
                  last_q     <= i_tx_last;
                  rx_sh_q    <= '0;
                  bit_q      <= '0;
                  lead_q     <= 1'b1;
                  if (!i_cpha) mosi_q <= i_tx_data[bit_pos(i_lsb_first, len_in, '0)];
                  state_q    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tick) state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (tick) begin
                  if (lead_q) begin
                     sclk_q <= ~cpol_q;
                     lead_q <= 1'b0;
                     if (cpha_q) mosi_q  <= tx_q[pos_cur];
                     else        rx_sh_q <= rx_sh_d;
                  end else begin
                     sclk_q <= cpol_q;
                     lead_q <= 1'b1;
                     if (cpha_q) rx_sh_q <= rx_sh_d;
                     if (bit_q == len_q - LW'(1)) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= cpha_q ? rx_sh_d : rx_sh_q;
                        if (last_q) begin
                           state_q <= ST_STOP;
                        end else begin
                           state_q    <= ST_WAIT;
                           tx_ready_q <= 1'b1;
                        end
                     end else begin
                        bit_q <= bit_q + LW'(1);
                        if (!cpha_q) mosi_q <= tx_q[pos_nxt];
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (accept) begin
                  tx_ready_q <= 1'b0;
                  cnt_q      <= '0;
                  div_q      <= i_divider;
                  tx_q       <= i_tx_data;
                  last_q     <= i_tx_last;
                  rx_sh_q    <= '0;
                  bit_q      <= '0;
                  lead_q     <= 1'b1;
                  if (!cpha_q) mosi_q <= i_tx_data[bit_pos(lsb_q, len_q, '0)];
                  state_q    <= ST_SHIFT;
               end
            end
            ST_STOP: begin
               if (tick) begin
                  ss_n_q  <= '1;
                  mosi_q  <= 1'b0;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (tick) begin
                  busy_q     <= 1'b0;
                  tx_ready_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_tx_ready = tx_ready_q;
   assign o_rx_data  = rx_data_q;
   assign o_rx_valid = rx_valid_q;
   assign o_busy     = busy_q;
   assign o_sclk     = sclk_q;
   assign o_ss_n     = ss_n_q;
   assign o_mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_mw.sv
// Bench for spi_master_mw: a behavioural SPI slave watches the pins and builds expected words per transaction.
module tb_spi_master_mw;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NUM_SS = 4;
   localparam int unsigned DIV_W  = 16;
   localparam int unsigned LW     = $clog2(DATA_W + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DIV_W-1:0]  divider = '0;
   logic              cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
   logic [LW-1:0]     word_len = '0;
   logic [1:0]        ss_sel = '0;
   logic [31:0]       tx_data = '0;
   logic              tx_last = 1'b0, tx_valid = 1'b0;
   logic              tx_ready, rx_valid, busy, sclk, mosi;
   logic [31:0]       rx_data;
   logic [3:0]        ss_n;
   logic              miso = 1'b0;
`ifdef SPI_MASTER_MW_LOOPBACK_EN
   logic              loopback = 1'b0;
`endif

   int unsigned checks = 0, errors = 0;

   // Model configuration, written only by the main sequence.
   int unsigned cfg_len = 8;
   logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
   logic [3:0]  cfg_ss_exp = 4'hF;
   bit          miso_tie0 = 1'b0;
   bit          lb_mode = 1'b0;
   logic [31:0] slave_words[$];
   logic [31:0] tx_words[$];

   // Slave-model state, written only by the slave process.
   int unsigned k = 0, m = 0, sw_idx = 0;
   int unsigned lead_cnt = 0, tog_cnt = 0, ss_rel_cnt = 0, ss_bad_cnt = 0, busy_cycles = 0;
   logic [31:0] cap_word = '0;
   logic [31:0] mosi_caps[$];
   logic [31:0] rx_got[$];
   logic        prev_sclk = 1'b0;
   logic [3:0]  prev_ss = 4'hF;

   spi_master_mw #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_divider(divider), .i_cpol(cpol), .i_cpha(cpha),
      .i_lsb_first(lsb), .i_word_len(word_len), .i_ss_sel(ss_sel), .i_tx_data(tx_data),
      .i_tx_last(tx_last), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .o_rx_data(rx_data),
      .o_rx_valid(rx_valid), .o_busy(busy), .o_sclk(sclk), .o_ss_n(ss_n), .o_mosi(mosi),
      .i_miso(miso)
`ifdef SPI_MASTER_MW_LOOPBACK_EN
      , .i_loopback(loopback)
`endif
   );

   always #5 clk = ~clk;

   function automatic int unsigned eff_len(input int unsigned raw);
      return (raw == 0 || raw > DATA_W) ? DATA_W : raw;
   endfunction

   function automatic logic [31:0] len_mask(input int unsigned len);
      return (len >= 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
   endfunction

   // Wire order: MSB-first puts bit len-1 on the wire first, LSB-first bit 0.
   function automatic int unsigned bpos(input int unsigned i);
      return cfg_lsb ? i : (cfg_len - 1 - i);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sample_mosi();
      cap_word = cap_word | (32'(mosi) << bpos(m));
      m++;
      if (m >= cfg_len) begin
         mosi_caps.push_back(cap_word);
         cap_word = '0;
         m = 0;
      end
   endtask

   // Behavioural slave: sees each SCLK edge on the following falling i_clk edge.
   initial begin
      logic [31:0] w;
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1) rx_got.push_back(rx_data);
         if (busy === 1'b1) busy_cycles++;
         if (sclk !== prev_sclk) tog_cnt++;
         for (int j = 0; j < 4; j++) begin
            if (prev_ss[j] === 1'b0 && ss_n[j] === 1'b1) ss_rel_cnt++;
         end
         if (ss_n !== 4'hF && ss_n !== cfg_ss_exp) ss_bad_cnt++;
         if (ss_n === 4'hF) begin
            k = 0; m = 0; sw_idx = 0; cap_word = '0;
         end else if (sclk !== prev_sclk) begin
            if (sclk !== cfg_cpol) begin
               lead_cnt++;
               if (!cfg_cpha) sample_mosi();
            end else begin
               if (cfg_cpha) sample_mosi();
               k++;
               if (k >= cfg_len) begin
                  k = 0;
                  sw_idx++;
               end
            end
         end
         prev_sclk = sclk;
         prev_ss = ss_n;
         if (miso_tie0 || sw_idx >= slave_words.size()) begin
            miso = 1'b0;
         end else begin
            w = slave_words[sw_idx];
            miso = 1'((w >> bpos(k)) & 32'h1);
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input logic last);
      int n = 0;
      @(negedge clk);
      tx_data = d;
      tx_last = last;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("tx_ready_hs", 32'(tx_ready), 32'h1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_end"}, 32'(busy), 32'h0);
   endtask

   task automatic setup_cfg(input logic pol, input logic pha, input logic l, input int unsigned raw_len,
                            input int unsigned div, input int unsigned sel);
      cpol = pol; cpha = pha; lsb = l;
      word_len = LW'(raw_len);
      divider = DIV_W'(div);
      ss_sel = 2'(sel);
      cfg_cpol = pol; cfg_cpha = pha; cfg_lsb = l;
      cfg_len = eff_len(raw_len);
      cfg_ss_exp = ~(4'h1 << sel);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_xfer(input string tag, input logic pol, input logic pha, input logic l,
                           input int unsigned raw_len, input int unsigned div, input int unsigned sel,
                           input int unsigned stall_at, input int unsigned stall_len);
      int unsigned len, nw, cap0, rx0, lead0, rel0, bad0, bc0, d, lo, hi;
      logic [31:0] msk, expw;
      setup_cfg(pol, pha, l, raw_len, div, sel);
      len = eff_len(raw_len);
      msk = len_mask(len);
      nw = tx_words.size();
      check({tag, "_idle_sclk"}, 32'(sclk), 32'(pol));
      cap0 = mosi_caps.size(); rx0 = rx_got.size(); lead0 = lead_cnt;
      rel0 = ss_rel_cnt; bad0 = ss_bad_cnt; bc0 = busy_cycles;
      for (int unsigned i = 0; i < nw; i++) begin
         if (i == stall_at) begin
            repeat (stall_len) @(negedge clk);
            check({tag, "_stall_sclk"}, 32'(sclk), 32'(pol));
            check({tag, "_stall_ss"}, 32'(ss_n), 32'(cfg_ss_exp));
            check({tag, "_stall_ready"}, 32'(tx_ready), 32'h1);
         end
         send_word(tx_words[i], (i == nw - 1));
      end
      wait_idle(tag);
      check({tag, "_ncap"}, mosi_caps.size() - cap0, nw);
      check({tag, "_nrx"}, rx_got.size() - rx0, nw);
      for (int unsigned i = 0; i < nw; i++) begin
         if (cap0 + i < mosi_caps.size())
            check({tag, "_mosi"}, mosi_caps[cap0 + i], tx_words[i] & msk);
         expw = lb_mode ? tx_words[i] : slave_words[i];
         if (rx0 + i < rx_got.size())
            check({tag, "_rx"}, rx_got[rx0 + i], expw & msk);
      end
      check({tag, "_edges"}, lead_cnt - lead0, nw * len);
      check({tag, "_ss_release"}, ss_rel_cnt - rel0, 1);
      check({tag, "_ss_onehot"}, ss_bad_cnt - bad0, 0);
      check({tag, "_end_mosi"}, 32'(mosi), 32'h0);
      check({tag, "_end_ss"}, 32'(ss_n), 32'hF);
      if (nw == 1) begin
         d = busy_cycles - bc0;
         lo = (2 * len + 2) * (div + 1) + 1;
         hi = (2 * len + 4) * (div + 1);
         check({tag, "_busy_len_ok"}, 32'(d >= lo && d <= hi), 32'h1);
      end
   endtask

   initial begin
      int unsigned n, lead0, rx0, tog0, nw;
      #12;
      check("rst_ss_n", 32'(ss_n), 32'hF);
      check("rst_sclk", 32'(sclk), 32'h0);
      check("rst_mosi", 32'(mosi), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ready", 32'(tx_ready), 32'h0);
      check("rst_rx_valid", 32'(rx_valid), 32'h0);
      check("rst_rx_data", rx_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ready", 32'(tx_ready), 32'h1);

      // Mode 0, 8 bits, MSB first, divider 1; slave returns the same pattern.
      tx_words = '{32'hA5};
      slave_words = '{32'hA5};
      run_xfer("t1", 1'b0, 1'b0, 1'b0, 8, 1, 2, 99, 0);

      // All four modes, 16-bit words.
      for (int md = 0; md < 4; md++) begin
         tx_words = '{32'h1234};
         slave_words = '{32'hBEEF};
         run_xfer("t2", 1'(md >> 1), 1'(md & 1), 1'b0, 16, 2, md, 99, 0);
      end

      // Three-word burst with a stall before the second word.
      tx_words = '{32'h11, 32'h22, 32'h33};
      slave_words = '{$urandom, $urandom, $urandom};
      run_xfer("t3", 1'b0, 1'b0, 1'b0, 8, 1, 0, 1, 50);

      // LSB first, 5 bits.
      tx_words = '{32'h13};
      slave_words = '{$urandom};
      run_xfer("t4", 1'b0, 1'b0, 1'b1, 5, 0, 3, 99, 0);

      // Reset during bit 3 in mode 3 aborts immediately.
      setup_cfg(1'b1, 1'b1, 1'b0, 8, 3, 1);
      slave_words = '{32'h3C};
      lead0 = lead_cnt;
      rx0 = rx_got.size();
      send_word(32'h5A, 1'b1);
      n = 0;
      while (lead_cnt - lead0 < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reached", lead_cnt - lead0, 3);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_ss", 32'(ss_n), 32'hF);
      check("rst_mid_sclk", 32'(sclk), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_mosi", 32'(mosi), 32'h0);
      check("rst_mid_ready", 32'(tx_ready), 32'h0);
      @(negedge clk);
      tog0 = tog_cnt;
      repeat (8) @(negedge clk);
      check("rst_mid_no_edges", tog_cnt - tog0, 0);
      check("rst_mid_no_rx", rx_got.size() - rx0, 0);
      rst_n = 1'b1;
      tx_words = '{32'hC3};
      slave_words = '{32'h96};
      run_xfer("t5", 1'b0, 1'b0, 1'b0, 8, 0, 1, 99, 0);

      // Randomised transactions: mode, order, length (0 and 33 mean 32), divider, select, burst size.
      for (int t = 0; t < 10; t++) begin
         nw = $urandom_range(1, 3);
         tx_words.delete();
         slave_words.delete();
         for (int unsigned i = 0; i < nw; i++) begin
            tx_words.push_back($urandom);
            slave_words.push_back($urandom);
         end
         run_xfer("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 33), $urandom_range(0, 2), $urandom_range(0, 3),
                  (nw > 1) ? 1 : 99, 220);
      end

`ifdef SPI_MASTER_MW_LOOPBACK_EN
      loopback = 1'b1;
      miso_tie0 = 1'b1;
      lb_mode = 1'b1;
      tx_words = '{32'hDEADBEEF};
      slave_words = '{32'h0};
      run_xfer("t6", 1'b0, 1'b0, 1'b0, 32, 1, 0, 99, 0);
      loopback = 1'b0;
      miso_tie0 = 1'b0;
      lb_mode = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
